// File: rtl/acc_out_port_pkg.sv
// Shared definitions for the accumulator output port.
//   NibbleWidth  : data width of the accumulator (4 bits)
//   DefaultDepth : default number of FIFO entries
//   occ_e/occ_of : occupancy classification derived from the entry count
package acc_out_port_pkg;

    localparam int unsigned NibbleWidth  = 4;
    localparam int unsigned DefaultDepth = 4;

    typedef enum logic [1:0] {
        OccEmpty,
        OccActive,
        OccFull
    } occ_e;

    function automatic occ_e occ_of(input int unsigned level, input int unsigned depth);
        if (level == 0) begin
            return OccEmpty;
        end else if (level >= depth) begin
            return OccFull;
        end else begin
            return OccActive;
        end
    endfunction

endpackage

// File: rtl/out_fifo_mem.sv
// Storage array for the output FIFO: DEPTH x WIDTH registers.
//   CLK   : clock; the write happens on posedge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : contents of entry raddr (combinational)
module out_fifo_mem
    import acc_out_port_pkg::*;
#(
    parameter int unsigned WIDTH = NibbleWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are not reset; nothing is read from an entry before it is written.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/acc_out_port.sv
// Output-side consumer of the accumulator. Each out_en strobe pushes acc_q into a small FIFO;
// the FIFO head is offered to an external device over a valid/ready handshake.
//   CLK        : system clock
//   RESET      : synchronous, active-high reset
//   acc_q      : current accumulator value
//   out_en     : push acc_q this cycle
//   full       : FIFO holds DEPTH entries (registered)
//   overflow   : sticky; a push was dropped because the FIFO was full
//   level      : number of entries held
//   port_data  : FIFO head offered to the peripheral (registered)
//   port_valid : port_data is valid (registered)
//   port_ready : peripheral accepts port_data this cycle
module acc_out_port
    import acc_out_port_pkg::*;
#(
    parameter int unsigned WIDTH = NibbleWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned LvlW = PtrW + 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [WIDTH-1:0] acc_q,
    input  logic            out_en,
    output logic            full,
    output logic            overflow,
    output logic [LvlW-1:0] level,
    output logic [WIDTH-1:0] port_data,
    output logic            port_valid,
    input  logic            port_ready
);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             port_valid_q, port_valid_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] port_data_q, port_data_d;
    logic [WIDTH-1:0] mem_rdata;
    logic             push, pop, head_bypass;
    occ_e             occ;

    always_comb begin
        occ      = occ_of(32'(level_q), DEPTH);
        pop      = port_valid_q & port_ready;
        // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
        push     = out_en & ((occ != OccFull) | pop);
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        level_d  = level_q + LvlW'(push) - LvlW'(pop);

        // The new head is the nibble being written this cycle when nothing else remains ahead of
        // it; the array only holds it after the edge, so take it straight from acc_q.
        head_bypass = push & ((level_q - LvlW'(pop)) == '0);

        port_valid_d = (level_d != '0);
        full_d       = (level_d == LvlW'(DEPTH));
        overflow_d   = overflow_q | (out_en & ~push);

        port_data_d = port_data_q;
        if (head_bypass) begin
            port_data_d = acc_q;
        end else if (port_valid_d) begin
            port_data_d = mem_rdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            port_valid_q <= 1'b0;
            port_data_q  <= '0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            port_valid_q <= port_valid_d;
            port_data_q  <= port_data_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
        end
    end

    // Writes are gated by RESET so a push coinciding with reset leaves no trace.
    out_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (push & ~RESET),
        .waddr (wr_ptr_q),
        .wdata (acc_q),
        .raddr (rd_ptr_d),
        .rdata (mem_rdata)
    );

    assign full       = full_q;
    assign overflow   = overflow_q;
    assign level      = level_q;
    assign port_data  = port_data_q;
    assign port_valid = port_valid_q;

endmodule

// File: tb/tb_acc_out_port.sv
module tb_acc_out_port;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [W-1:0] acc_q;
    logic         out_en;
    logic         full;
    logic         overflow;
    logic [2:0]   level;
    logic [W-1:0] port_data;
    logic         port_valid;
    logic         port_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending nibbles plus the sticky flag and last shown head.
    logic [W-1:0] mq[$];
    bit           m_ovf;
    logic [W-1:0] m_last;

    acc_out_port #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .acc_q      (acc_q),
        .out_en     (out_en),
        .full       (full),
        .overflow   (overflow),
        .level      (level),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_ready (port_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output after the edge.
    task automatic step(input bit rst, input bit en, input logic [W-1:0] d, input bit rdy,
                        input string tag);
        bit popped;
        int sz;
        RESET = rst; out_en = en; acc_q = d; port_ready = rdy;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            m_ovf  = 0;
            m_last = '0;
        end else begin
            popped = (sz != 0) && rdy;
            if (popped) void'(mq.pop_front());
            if (en) begin
                if (sz < D || popped) mq.push_back(d);
                else m_ovf = 1;
            end
            if (mq.size() != 0) m_last = mq[0];
        end
        @(posedge CLK);
        #1;
        chk({tag, ".valid"}, 32'(port_valid), 32'(mq.size() != 0));
        chk({tag, ".data"},  32'(port_data),  32'(m_last));
        chk({tag, ".level"}, 32'(level),      32'(mq.size()));
        chk({tag, ".full"},  32'(full),       32'(mq.size() == D));
        chk({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
    endtask

    initial begin
        RESET = 1'b1; out_en = 1'b0; acc_q = '0; port_ready = 1'b0;
        mq.delete(); m_ovf = 0; m_last = '0;

        // 1: reset with a push strobe held; reset must win
        step(1, 1, 4'hF, 0, "t1");
        step(1, 1, 4'hF, 0, "t1");
        chk("t1_level0", 32'(level), 0);
        chk("t1_data0", 32'(port_data), 0);

        // 2: single push, then stall five cycles
        step(0, 1, 4'h3, 0, "t2_push");
        chk("t2_data3", 32'(port_data), 32'h3);
        for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 0, "t2_stall");
        chk("t2_stable", 32'(port_data), 32'h3);
        step(0, 0, 4'h0, 1, "t2_drain");
        chk("t2_empty", 32'(port_valid), 0);

        // 3: fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) step(0, 1, 4'(i), 0, "t3_fill");
        chk("t3_full", 32'(full), 1);
        step(0, 1, 4'h5, 0, "t3_ovf");
        chk("t3_ovf_set", 32'(overflow), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 1, "t3_drain");

        // 4: push and pop together while full
        step(1, 0, 4'h0, 0, "t4_rst");
        for (int i = 1; i <= 4; i++) step(0, 1, 4'(i), 0, "t4_fill");
        step(0, 1, 4'hA, 1, "t4_both");
        chk("t4_level4", 32'(level), 4);
        chk("t4_no_ovf", 32'(overflow), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 1, "t4_drain");

        // 5: streaming with ready held high across pointer wrap
        for (int i = 0; i < 8; i++) step(0, 1, 4'(i), 1, "t5_stream");
        step(0, 0, 4'h0, 1, "t5_tail");
        step(0, 0, 4'h0, 1, "t5_idle");

        // 6: reset during an active transfer
        for (int i = 0; i < 3; i++) step(0, 1, 4'(9 + i), 0, "t6_fill");
        chk("t6_level3", 32'(level), 3);
        step(1, 1, 4'h7, 1, "t6_rst");
        step(0, 0, 4'h0, 1, "t6_after");
        step(0, 0, 4'h0, 1, "t6_after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 60),
                 4'($urandom), ($urandom_range(0, 99) < 50), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
